// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth sequential multiplier sequencing controller.
// Optional macro BOOTH_SKIP_EN: no-op decisions bypass the ADD state.

typedef struct packed {
   logic load_A;
   logic load_B;
   logic load_add;
   logic shift_HQ_LQ_Q_1;
   logic add_sub;
} mult_control_t;

module booth_mult_ctrl #(
   parameter int unsigned N = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [1:0]               Q_LSB,
   output mult_control_t            mult_control,
   output logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(N+1)-1:0]   iter
);

   localparam int unsigned IW = $clog2(N + 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StEval,
      StAdd,
      StShift,
      StDone
   } state_e;

   state_e        state_q, state_d;
   mult_control_t ctrl_d;
   logic          ready_d;
   logic          done_d;
   logic [IW-1:0] iter_d;
   logic          do_op;

   assign do_op = (Q_LSB == 2'b01) || (Q_LSB == 2'b10);
   assign busy  = ~ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  state_d = StEval;
`ifdef BOOTH_SKIP_EN
         StEval:  state_d = do_op ? StAdd : StShift;
`else
         StEval:  state_d = StAdd;
`endif
         StAdd:   state_d = StShift;
         StShift: state_d = (iter == IW'(1)) ? StDone : StEval;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort && (state_q != StIdle)) state_d = StIdle;
   end

   // Strobes are registered from the next state so each one lines up with its state cycle.
   // StAdd is only entered from StEval, so Q_LSB here is the EVAL-cycle decision.
   always_comb begin
      ctrl_d                 = '0;
      ctrl_d.load_A          = (state_d == StLoad);
      ctrl_d.load_B          = (state_d == StLoad);
      ctrl_d.load_add        = (state_d == StAdd) && do_op;
      ctrl_d.add_sub         = (state_d == StAdd) && (Q_LSB == 2'b10);
      ctrl_d.shift_HQ_LQ_Q_1 = (state_d == StShift);
      ready_d                = (state_d == StIdle);
      done_d                 = (state_d == StDone);
      iter_d                 = iter;
      if (state_d == StLoad) begin
         iter_d = IW'(N);
      end else if ((state_q == StShift) && (state_d != StIdle)) begin
         iter_d = iter - IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         mult_control <= '0;
         ready        <= 1'b1;
         done         <= 1'b0;
         iter         <= '0;
      end else begin
         state_q      <= state_d;
         mult_control <= ctrl_d;
         ready        <= ready_d;
         done         <= done_d;
         iter         <= iter_d;
      end
   end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl: directed Q_LSB patterns, abort, reset, back-to-back.
// Expected latencies follow BOOTH_SKIP_EN when it is defined for the build.

module tb_booth_mult_ctrl;

   localparam int unsigned N  = 8;
   localparam int          IW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    q_lsb;
   mult_control_t mc;
   logic          ready, busy, done;
   logic [IW-1:0] iter;

   booth_mult_ctrl #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .Q_LSB        (q_lsb),
      .mult_control (mc),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .iter         (iter)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          lat;
      int          sh;
      int          adds;
      int          subs;
      logic [15:0] sig;
   } exp_t;

   // Q_LSB per iteration i at bits [2i+1:2i]; sig holds observed {load_add, add_sub} per iteration.
   localparam logic [15:0] PAT [5]    = '{16'h0000, 16'h3939, 16'hAAAA, 16'h5555, 16'h1111};
   localparam logic [15:0] SIG [5]    = '{16'h0000, 16'h0E0E, 16'hFFFF, 16'hAAAA, 16'h2222};
   localparam int          ADDS [5]   = '{0, 4, 8, 8, 4};
   localparam int          SUBS [5]   = '{0, 2, 8, 0, 0};
   localparam int          LAT_NS [5] = '{26, 26, 26, 26, 26};
   localparam int          LAT_SK [5] = '{18, 22, 26, 26, 22};

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] cur_pat = 16'h0000;
   int          mon_sh = 0;

   // Datapath stand-in: next Q_LSB pair after each observed shift.
   assign q_lsb = 2'(cur_pat >> (2 * mon_sh));

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input int v);
      exp_t e;
`ifdef BOOTH_SKIP_EN
      e.lat = LAT_SK[v];
`else
      e.lat = LAT_NS[v];
`endif
      e.sh   = N;
      e.adds = ADDS[v];
      e.subs = SUBS[v];
      e.sig  = SIG[v];
      return e;
   endfunction

   // Monitor
   initial begin
      int          cyc;
      bit          active;
      logic        pla, pas;
      int          adds, subs;
      logic [15:0] sig;
      exp_t        e;
      cyc = 0; active = 0; pla = 0; pas = 0; adds = 0; subs = 0; sig = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            active = 0;
            pla = 0;
            pas = 0;
            continue;
         end
         check("onehot", ($countones({mc.load_A, mc.load_add, mc.shift_HQ_LQ_Q_1}) <= 1) ? 1 : 0, 1);
         check("load_ab_pair", int'(mc.load_A), int'(mc.load_B));
         check("addsub_gated", (mc.add_sub && !mc.load_add) ? 1 : 0, 0);
         check("busy_inv", int'(busy), ready ? 0 : 1);
         if (mc.load_A) begin
            check("iter_load", int'(iter), N);
            cyc = 1; mon_sh = 0; adds = 0; subs = 0; sig = '0; active = 1;
         end else if (active) begin
            cyc++;
         end
         if (mc.load_add) adds++;
         if (mc.add_sub) subs++;
         if (mc.shift_HQ_LQ_Q_1) begin
            if (mon_sh < 8) sig[2*mon_sh +: 2] = {pla, pas};
            mon_sh++;
         end
         pla = mc.load_add;
         pas = mc.add_sub;
         if (done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("latency", cyc, e.lat);
               check("shifts", mon_sh, e.sh);
               check("load_add_cnt", adds, e.adds);
               check("add_sub_cnt", subs, e.subs);
               check("decode_sig", int'(sig), int'(e.sig));
               check("iter_done", int'(iter), 0);
            end
            active = 0;
         end
      end
   end

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      check(name, int'(done), 1);
   endtask

   task automatic run_op(input int v);
      cur_pat = PAT[v];
      exp_q.push_back(mk(v));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("accept_load", int'(mc.load_A), 1);
      wait_done("done_seen");
   endtask

   // Stimulus
   initial begin
      int n;
      int nsh;
      rst = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", int'(ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ctrl", int'(mc), 0);
      check("rst_iter", int'(iter), 0);

      exp_q.push_back(mk(0));
      rst = 1'b1;
      @(negedge clk);
      check("release_load", int'(mc.load_A), 1);
      start = 1'b0;
      wait_done("release_done");

      for (int v = 0; v < 5; v++) run_op(v);

      // Abort on the third SHIFT cycle; no done may follow.
      cur_pat = PAT[1];
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nsh = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (mc.shift_HQ_LQ_Q_1) nsh++;
      end while (nsh < 3 && n < 100);
      check("abort_reach", nsh, 3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_ready", int'(ready), 1);
      check("abort_ctrl", int'(mc), 0);
      check("abort_done", int'(done), 0);
      repeat (30) @(negedge clk);
      run_op(1);

      // Asynchronous reset in the middle of an operation.
      cur_pat = PAT[2];
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_ready", int'(ready), 1);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_ctrl", int'(mc), 0);
      check("mid_rst_iter", int'(iter), 0);
      check("mid_rst_done", int'(done), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);

      // Back-to-back with start held high.
      cur_pat = PAT[0];
      exp_q.push_back(mk(0));
      exp_q.push_back(mk(0));
      @(negedge clk);
      start = 1'b1;
      wait_done("b2b_first_done");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mc.load_A && n < 10);
      check("b2b_gap", n, 2);
      start = 1'b0;
      wait_done("b2b_second_done");

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
